// File: rtl/barrett_cs_finalizer.sv
// Barrett carry-save finalizer: chunked carry-propagate add, m-bit guard drop, bounded
// conditional subtraction of M. Optional status output guarded by BARRETT_FIN_STATUS_EN.
module barrett_cs_finalizer #(
   parameter int n    = 24,
   parameter int m    = 4,
   parameter int CW   = 8,
   parameter int NSUB = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [n+m+11:0]   in_zs,
   input  logic [n+m+11:0]   in_zc,
   input  logic [n-1:0]      in_m,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [n-1:0]      out_z
`ifdef BARRETT_FIN_STATUS_EN
   ,
   output logic              out_err
`endif
);

   localparam int W    = n + m + 12;
   localparam int NCH  = (W + CW - 1) / CW;
   localparam int PW   = NCH * CW;
   localparam int ZW   = n + m + 2;
   localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CNTW = $clog2(NSUB + 1);

   typedef enum logic [1:0] {IDLE, ADD, SUB, DONE} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     a_r, b_r, s_r, s_next;
   logic              carry;
   logic [IW-1:0]     idx;
   logic [n-1:0]      m_r;
   logic [ZW-1:0]     z_r, m_ext;
   logic [CNTW-1:0]   cnt;
   logic [CW:0]       sum_chunk;
   logic              last_chunk, z_ge, do_sub, accept;
   logic              unused_bits;

   // Operands shift right one chunk per cycle; sums shift in from the top so that
   // after NCH cycles s_next holds the full resolved word.
   assign sum_chunk  = {1'b0, a_r[CW-1:0]} + {1'b0, b_r[CW-1:0]} + {{CW{1'b0}}, carry};
   assign s_next     = {sum_chunk[CW-1:0], s_r[PW-1:CW]};
   assign last_chunk = (idx == IW'(NCH - 1));
   assign m_ext      = {{(ZW-n){1'b0}}, m_r};
   assign z_ge       = (z_r >= m_ext);
   // M=0 would otherwise satisfy Z>=M forever; treat it as "nothing to subtract"
   assign do_sub     = (m_r != '0) && z_ge && (cnt < CNTW'(NSUB));
   assign accept     = in_valid && in_ready;
   assign unused_bits = ^s_next;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept)     state_nxt = ADD;
         ADD:  if (last_chunk) state_nxt = SUB;
         SUB:  if (!do_sub)    state_nxt = DONE;
         DONE: if (out_ready)  state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) && RST;
      out_valid = (state == DONE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         a_r   <= '0;
         b_r   <= '0;
         s_r   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         m_r   <= '0;
         z_r   <= '0;
         cnt   <= '0;
         out_z <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               a_r   <= PW'(in_zs);
               b_r   <= PW'(in_zc);
               m_r   <= in_m;
               carry <= 1'b0;
               idx   <= '0;
               cnt   <= '0;
            end
            ADD: begin
               a_r   <= a_r >> CW;
               b_r   <= b_r >> CW;
               s_r   <= s_next;
               carry <= sum_chunk[CW];
               idx   <= idx + IW'(1);
               if (last_chunk) z_r <= s_next[m +: ZW];
            end
            SUB: begin
               if (do_sub) begin
                  z_r <= z_r - m_ext;
                  cnt <= cnt + CNTW'(1);
               end else begin
                  out_z <= z_r[n-1:0];
               end
            end
            default: ;
         endcase
      end
   end

`ifdef BARRETT_FIN_STATUS_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         out_err <= 1'b0;
      end else if (state == SUB && !do_sub) begin
         out_err <= ((m_r != '0) && z_ge) || (z_r[ZW-1:n] != '0);
      end else if (state == DONE && out_ready) begin
         out_err <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_barrett_cs_finalizer.sv
// Randomized self-checking bench for barrett_cs_finalizer against an arithmetic model.
module tb_barrett_cs_finalizer;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [39:0] in_zs = '0;
   logic [39:0] in_zc = '0;
   logic [23:0] in_m = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [23:0] out_z;
`ifdef BARRETT_FIN_STATUS_EN
   logic        out_err;
`endif

   barrett_cs_finalizer dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_zs(in_zs), .in_zc(in_zc), .in_m(in_m),
      .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z)
`ifdef BARRETT_FIN_STATUS_EN
      , .out_err(out_err)
`endif
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [23:0] z;
      int          lat;
      int          acc;
      bit          err;
   } exp_t;
   exp_t q[$];

   bit stall = 1'b0;
   int stall_cnt = 0;
   bit hs_pend = 1'b0;
   bit prev_v = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: resolve, drop 4 guard bits, keep 30 bits, subtract M at most twice.
   function automatic void model(input logic [39:0] zs, input logic [39:0] zc,
                                 input logic [23:0] mm, output logic [23:0] z,
                                 output int k, output bit err);
      longint s, zz;
      s  = (longint'(zs) + longint'(zc)) % (64'sd1 << 40);
      zz = (s / 16) % (64'sd1 << 30);
      k  = 0;
      while (mm != 0 && zz >= longint'(mm) && k < 2) begin
         zz = zz - longint'(mm);
         k++;
      end
      err = (mm != 0 && zz >= longint'(mm)) || (zz >= (64'sd1 << 24));
      z   = 24'(zz);
   endfunction

   always @(negedge CLK) begin
      if (!RST) begin
         hs_pend   = 1'b0;
         prev_v    = 1'b0;
         out_ready = 1'b0;
      end else begin
         if (hs_pend) begin
            if (q.size() > 0) q.delete(0);
            hs_pend = 1'b0;
            prev_v  = 1'b0;
         end
         if (prev_v) chk("valid_hold", out_valid, 1);
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_valid", q.size(), 1);
            end else begin
               if (!prev_v) chk("latency", cyc - q[0].acc, q[0].lat);
               chk("out_z", out_z, q[0].z);
               chk("in_ready_busy", in_ready, 0);
`ifdef BARRETT_FIN_STATUS_EN
               chk("out_err", out_err, q[0].err);
`endif
            end
            if (stall) stall_cnt++;
         end
         prev_v    = out_valid;
         out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
         if (out_valid && out_ready) hs_pend = 1'b1;
      end
   end

   task automatic send(input logic [39:0] zs, input logic [39:0] zc, input logic [23:0] mm);
      exp_t e;
      int   k;
      bit   got;
      got = 1'b0;
      model(zs, zc, mm, e.z, k, e.err);
      e.lat = 6 + k;
      @(negedge CLK);
      in_valid = 1'b1;
      in_zs = zs;
      in_zc = zc;
      in_m  = mm;
      for (int t = 0; t < 100 && !got; t++) begin
         if (in_ready) begin
            e.acc = cyc + 1;
            q.push_back(e);
            got = 1'b1;
         end
         @(negedge CLK);
      end
      in_valid = 1'b0;
      chk("accept_timeout", got, 1);
   endtask

   task automatic drain();
      for (int t = 0; t < 500 && q.size() > 0; t++) @(negedge CLK);
      chk("drain_timeout", q.size(), 0);
   endtask

   task automatic send_rand();
      logic [39:0] zs, zc;
      logic [23:0] mm;
      longint      zt, full;
      int          r;
      r = int'($urandom_range(0, 9));
      if (r == 0)      mm = '0;
      else if (r < 4)  mm = 24'($urandom_range(1, 1000));
      else             mm = 24'($urandom());
      zc = 40'({$urandom(), $urandom()});
      if ($urandom_range(0, 1) == 1) begin
         zt = longint'(mm) * longint'($urandom_range(0, 3)) + longint'($urandom_range(0, 2));
         zt = (zt > 0) ? zt - 1 : 0;
         full = zt * 16 + longint'($urandom_range(0, 15));
         zs = 40'(full - longint'(zc));
      end else begin
         zs = 40'({$urandom(), $urandom()});
      end
      send(zs, zc, mm);
   endtask

   initial begin
      logic [23:0] pz;
      int          pk;
      bit          pe;

      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_z", out_z, 0);
      chk("rst_in_ready", in_ready, 0);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      model(40'h160, 40'h0A0, 24'd100, pz, pk, pe);
      chk("pin_t1_z", pz, 32);  chk("pin_t1_k", pk, 0);
      model(40'h640, 40'h0, 24'd100, pz, pk, pe);
      chk("pin_t2_z", pz, 0);   chk("pin_t2_k", pk, 1);
      model(40'hFA0, 40'h0, 24'd100, pz, pk, pe);
      chk("pin_t3_z", pz, 50);  chk("pin_t3_k", pk, 2);
      model(40'h000FFFFFF0, 40'h10, 24'hFFFFFF, pz, pk, pe);
      chk("pin_t4_z", pz, 1);   chk("pin_t4_k", pk, 1);
      model(40'h15E0, 40'h0, 24'd100, pz, pk, pe);
      chk("pin_t5_z", pz, 150); chk("pin_t5_err", pe, 1);

      send(40'h160, 40'h0A0, 24'd100);
      send(40'h640, 40'h0, 24'd100);
      send(40'hFA0, 40'h0, 24'd100);
      send(40'h000FFFFFF0, 40'h10, 24'hFFFFFF);
      send(40'h15E0, 40'h0, 24'd100);
      send(40'h160, 40'h0A0, 24'd0);
      drain();

      for (int i = 0; i < 40; i++) send_rand();
      drain();

      stall = 1'b1;
      stall_cnt = 0;
      send(40'h160, 40'h0A0, 24'd100);
      for (int t = 0; t < 100 && stall_cnt < 10; t++) @(negedge CLK);
      chk("stall_cycles", stall_cnt >= 10, 1);
      stall = 1'b0;
      drain();

      send(40'h123456789A, 40'h0FEDCBA987, 24'h3FFFF);
      @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      chk("midop_rst_out_valid", out_valid, 0);
      chk("midop_rst_out_z", out_z, 0);
      chk("midop_rst_in_ready", in_ready, 0);
      q.delete();
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("rel_in_ready", in_ready, 1);

      send(40'hFA0, 40'h0, 24'd100);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
